cache_fill_fsm: RTL and testbench

- Miss-handling controller between the pipeline's L1 caches (instruction and data) and the multi-cycle main memory.
- On a cache miss it stalls the requesting stage and fetches the aligned block one word per cycle.
- It writes each returned word into the cache data array, then writes the tag on the last beat and releases the stall.
- One instance serves each cache; arbitration between the two instances is outside this block.

---
 rtl/cache_fill_fsm.sv | 113 +++++++++++
 tb/tb_cache_fill_fsm.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: stalls the pipeline, streams one aligned block
// from main memory into the data array, then writes the tag and releases.
module cache_fill_fsm #(
  parameter int WORDS      = 8,
  parameter int WORD_BYTES = 2,
  parameter int ADDR_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       miss_detected,
  input  logic [ADDR_W-1:0]          miss_address,
  input  logic [15:0]                memory_data,
  input  logic                       memory_data_valid,
  output logic                       fsm_busy,
  output logic                       memory_req,
  output logic [ADDR_W-1:0]          memory_address,
  output logic                       write_data_array,
  output logic                       write_tag_array,
  output logic [$clog2(WORDS)-1:0]   fill_word,
  output logic [15:0]                fill_data,
  output logic [ADDR_W-1:0]          base_addr
);

  localparam int IDX_W = $clog2(WORDS);
  localparam int CNT_W = $clog2(WORDS) + 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(WORDS * WORD_BYTES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   req_cnt_q, req_cnt_d;
  logic [IDX_W-1:0]   recv_cnt_q, recv_cnt_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic               req_s;
  logic               wr_s;
  logic               last_s;

  // Request/receive qualifiers derived from the current state
  always_comb begin
    req_s  = (state_q == FILL) && (req_cnt_q < CNT_W'(WORDS));
    wr_s   = (state_q == FILL) && memory_data_valid;
    last_s = wr_s && (recv_cnt_q == IDX_W'(WORDS - 1));
  end

  // Next-state and counter update
  always_comb begin
    state_d    = state_q;
    req_cnt_d  = req_cnt_q;
    recv_cnt_d = recv_cnt_q;
    base_d     = base_q;
    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          base_d     = miss_address & ~OFF_MASK;
          req_cnt_d  = {CNT_W{1'b0}};
          recv_cnt_d = {IDX_W{1'b0}};
          state_d    = FILL;
        end else begin
          state_d    = IDLE;
        end
      end
      FILL: begin
        if (req_s) begin
          req_cnt_d = req_cnt_q + CNT_W'(1);
        end else begin
          req_cnt_d = req_cnt_q;
        end
        // The beat counter wraps to zero on the last beat, ready for the next miss
        if (wr_s) begin
          recv_cnt_d = last_s ? {IDX_W{1'b0}} : recv_cnt_q + IDX_W'(1);
          state_d    = last_s ? IDLE : FILL;
        end else begin
          recv_cnt_d = recv_cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_cnt_q  <= {CNT_W{1'b0}};
      recv_cnt_q <= {IDX_W{1'b0}};
      base_q     <= {ADDR_W{1'b0}};
    end else begin
      state_q    <= state_d;
      req_cnt_q  <= req_cnt_d;
      recv_cnt_q <= recv_cnt_d;
      base_q     <= base_d;
    end
  end

  // Outputs; busy follows the miss in IDLE so the stall lands in the miss cycle
  always_comb begin
    fsm_busy         = rst_n && ((state_q == FILL) || miss_detected);
    memory_req       = req_s;
    memory_address   = req_s ? (base_q + (ADDR_W'(req_cnt_q) * ADDR_W'(WORD_BYTES)))
                             : {ADDR_W{1'b0}};
    write_data_array = wr_s;
    write_tag_array  = last_s;
    fill_word        = wr_s ? recv_cnt_q : {IDX_W{1'b0}};
    fill_data        = wr_s ? memory_data : 16'h0000;
    base_addr        = base_q;
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: randomized-latency memory model,
// block-level reference model and per-cycle compare, plus directed scenarios.
module tb_cache_fill_fsm;

  localparam int WORDS  = 8;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              miss_detected = 1'b0;
  logic [ADDR_W-1:0] miss_address = 16'h0000;
  logic [15:0]       memory_data = 16'h0000;
  logic              memory_data_valid = 1'b0;
  logic              fsm_busy, memory_req, write_data_array, write_tag_array;
  logic [ADDR_W-1:0] memory_address, base_addr;
  logic [2:0]        fill_word;
  logic [15:0]       fill_data;

  cache_fill_fsm #(.WORDS(WORDS), .WORD_BYTES(2), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data(memory_data), .memory_data_valid(memory_data_valid),
    .fsm_busy(fsm_busy), .memory_req(memory_req), .memory_address(memory_address),
    .write_data_array(write_data_array), .write_tag_array(write_tag_array),
    .fill_word(fill_word), .fill_data(fill_data), .base_addr(base_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // memory model: in-order responses, each at least lat_min..lat_max cycles after its request
  int          cyc = 0;
  int          due_q[$];
  logic [15:0] dat_q[$];
  int          last_due = 0;
  int          lat_min = 4;
  int          lat_max = 4;
  logic        man_valid = 1'b0;
  logic [15:0] man_data = 16'h0000;

  initial forever begin
    @(posedge clk);
    #2;
    cyc++;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      memory_data_valid = 1'b1;
      memory_data       = dat_q[0];
      void'(due_q.pop_front());
      void'(dat_q.pop_front());
    end else begin
      memory_data_valid = man_valid;
      memory_data       = man_valid ? man_data : 16'($urandom);
    end
  end

  // reference model: expected block addresses still to be requested, beats received
  bit          m_active = 1'b0;
  logic [15:0] m_base = 16'h0000;
  logic [15:0] m_addr_q[$];
  int          m_recv = 0;

  int          n_req = 0, n_wr = 0, n_tag = 0, tag_at = -1, first_word = -1, wrap_seen = 0;
  logic [15:0] last_req = 16'h0000;

  task automatic clear_stats();
    n_req = 0; n_wr = 0; n_tag = 0; tag_at = -1; first_word = -1; wrap_seen = 0;
    last_req = 16'h0000;
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_busy", fsm_busy, 1'b0);
      chk("rst_req", memory_req, 1'b0);
      chk("rst_wr", write_data_array, 1'b0);
      chk("rst_tag", write_tag_array, 1'b0);
      m_active = 1'b0; m_base = 16'h0000; m_recv = 0; m_addr_q.delete();
      due_q.delete(); dat_q.delete(); last_due = 0;
    end else begin
      bit          e_req, e_wr, e_tag;
      logic [15:0] e_addr;
      e_req  = m_active && (m_addr_q.size() > 0);
      e_addr = e_req ? m_addr_q[0] : 16'h0000;
      e_wr   = m_active && memory_data_valid;
      e_tag  = e_wr && (m_recv == WORDS - 1);
      chk("busy", fsm_busy, m_active || miss_detected);
      chk("mem_req", memory_req, e_req);
      chk("mem_addr", memory_address, e_addr);
      chk("wr_data", write_data_array, e_wr);
      chk("wr_tag", write_tag_array, e_tag);
      chk("base", base_addr, m_base);
      if (e_wr) begin
        chk("fill_word", fill_word, m_recv[2:0]);
        chk("fill_data", fill_data, memory_data);
      end
      if (memory_req) begin
        int due;
        n_req++;
        last_req = memory_address;
        if (memory_address < base_addr) wrap_seen = 1;
        due = cyc + int'($urandom_range(lat_max, lat_min));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        due_q.push_back(due);
        dat_q.push_back(16'($urandom));
      end
      if (write_data_array) begin
        n_wr++;
        if (n_wr == 1) first_word = int'(fill_word);
      end
      if (write_tag_array) begin
        n_tag++;
        tag_at = n_wr;
      end
      if (m_active) begin
        if (e_req) void'(m_addr_q.pop_front());
        if (memory_data_valid) begin
          if (m_recv == WORDS - 1) m_active = 1'b0;
          m_recv++;
        end
      end else if (miss_detected) begin
        m_active = 1'b1;
        m_base   = miss_address & 16'hFFF0;
        m_recv   = 0;
        m_addr_q.delete();
        for (int i = 0; i < WORDS; i++) m_addr_q.push_back(m_base + 16'(2 * i));
      end
    end
  end

  task automatic start_miss(input logic [15:0] a);
    @(posedge clk);
    #1;
    miss_detected = 1'b1;
    miss_address  = a;
    @(posedge clk);
    #1;
    miss_detected = 1'b0;
  endtask

  task automatic wait_tag(input string name, input int budget);
    int t = 0;
    while (n_tag == 0 && t < budget) begin
      @(posedge clk);
      t++;
    end
    chk(name, n_tag != 0, 1'b1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // idle: memory_data_valid pulses must not write
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      man_valid = 1'b1;
      man_data  = 16'($urandom);
      @(negedge clk);
      chk("idle_wr", write_data_array, 1'b0);
      chk("idle_busy", fsm_busy, 1'b0);
      chk("idle_base", base_addr, 16'h0000);
    end
    @(posedge clk);
    #1 man_valid = 1'b0;
    repeat (2) @(posedge clk);

    // directed fill at 0x1236 with latency 4, cycle 0 is the miss cycle
    lat_min = 4; lat_max = 4;
    clear_stats();
    @(posedge clk);
    #1;
    miss_detected = 1'b1;
    miss_address  = 16'h1236;
    for (int k = 0; k <= 13; k++) begin
      int ea;
      @(negedge clk);
      ea = (k >= 1 && k <= 8) ? 16'h1230 + 2 * (k - 1) : 0;
      chk("d_busy", fsm_busy, k <= 12);
      chk("d_req", memory_req, k >= 1 && k <= 8);
      chk("d_addr", memory_address, ea);
      chk("d_wr", write_data_array, k >= 5 && k <= 12);
      chk("d_tag", write_tag_array, k == 12);
      if (k >= 5 && k <= 12) chk("d_word", fill_word, k - 5);
      if (k >= 1) chk("d_base", base_addr, 16'h1230);
      @(posedge clk);
      #1 miss_detected = 1'b0;
    end

    // top block with random per-beat latency
    lat_min = 4; lat_max = 7;
    clear_stats();
    start_miss(16'hFFFE);
    wait_tag("top_done", 200);
    repeat (2) @(posedge clk);
    chk("top_base", base_addr, 16'hFFF0);
    chk("top_last_req", last_req, 16'hFFFE);
    chk("top_wrap", wrap_seen, 0);
    chk("top_nreq", n_req, 8);
    chk("top_nwr", n_wr, 8);

    // random addresses and gaps
    for (int r = 0; r < 6; r++) begin
      clear_stats();
      start_miss(16'($urandom));
      wait_tag("rnd_done", 200);
      repeat (int'($urandom_range(3, 1))) @(posedge clk);
      chk("rnd_nwr", n_wr, 8);
      chk("rnd_ntag", n_tag, 1);
      chk("rnd_tag_at", tag_at, 8);
      chk("rnd_nreq", n_req, 8);
      chk("rnd_first", first_word, 0);
    end

    // miss held through a fill, then a new miss at 0x0040 right after
    clear_stats();
    @(posedge clk);
    #1;
    miss_detected = 1'b1;
    miss_address  = 16'h2000;
    wait_tag("hold_done", 200);
    #1;
    chk("hold_nwr", n_wr, 8);
    chk("hold_nreq", n_req, 8);
    chk("hold_base", base_addr, 16'h2000);
    clear_stats();
    miss_address = 16'h0040;
    @(posedge clk);
    #1 miss_detected = 1'b0;
    wait_tag("second_done", 200);
    #1;
    chk("second_base", base_addr, 16'h0040);
    chk("second_nwr", n_wr, 8);
    chk("second_first", first_word, 0);

    // asynchronous reset after three beats
    lat_min = 4; lat_max = 4;
    repeat (2) @(posedge clk);
    clear_stats();
    start_miss(16'h3456);
    begin
      int t = 0;
      while (n_wr < 3 && t < 100) begin
        @(posedge clk);
        t++;
      end
      chk("rst_three_beats", n_wr >= 3, 1'b1);
    end
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", fsm_busy, 1'b0);
    chk("arst_req", memory_req, 1'b0);
    chk("arst_addr", memory_address, 16'h0000);
    chk("arst_wr", write_data_array, 1'b0);
    chk("arst_tag", write_tag_array, 1'b0);
    chk("arst_word", fill_word, 3'd0);
    chk("arst_data", fill_data, 16'h0000);
    chk("arst_base", base_addr, 16'h0000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("arst_no_tag", n_tag, 0);
    repeat (2) @(posedge clk);
    clear_stats();
    start_miss(16'h0100);
    wait_tag("post_rst_done", 200);
    repeat (2) @(posedge clk);
    chk("post_rst_first", first_word, 0);
    chk("post_rst_nwr", n_wr, 8);
    chk("post_rst_base", base_addr, 16'h0100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
